// File: rtl/core_status_monitor.sv
// Receives the core's per-instruction status stream, logs each status with a sequence number,
// counts R/I-type successes and detects program termination (end, overflow, watchdog timeout).
module core_status_monitor #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [1:0]       i_status,
   input  logic             i_status_valid,
   output logic             o_rec_valid,
   output logic [9:0]       o_rec_data,
   input  logic             i_rec_ready,
   output logic [CNT_W-1:0] o_r_cnt,
   output logic [CNT_W-1:0] o_i_cnt,
   output logic             o_done,
   output logic [1:0]       o_cause,
   output logic             o_overrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CMAX  = '1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [9:0]    mem [DEPTH];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic [7:0]    seq;
   logic [TW-1:0] tcnt;

   logic empty;
   logic full;
   logic pop;
   logic push;
   logic push_ok;
   logic arm;

   assign empty       = (wptr == rptr);
   assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign o_rec_valid = !empty;
   assign o_rec_data  = empty ? 10'd0 : mem[rptr[AW-1:0]];
   assign pop         = o_rec_valid && i_rec_ready;
   assign push        = (state == RUN) && i_status_valid;
   // A full log can still accept a push when the head leaves in the same cycle.
   assign push_ok     = push && (!full || pop);
   assign arm         = i_start && (state != RUN);

   always_ff @(posedge i_clk) begin
      if (push_ok && !i_rst)
         mem[wptr[AW-1:0]] <= {seq, i_status};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || arm) begin
         state     <= i_rst ? IDLE : RUN;
         wptr      <= '0;
         rptr      <= '0;
         seq       <= '0;
         tcnt      <= '0;
         o_r_cnt   <= '0;
         o_i_cnt   <= '0;
         o_done    <= 1'b0;
         o_cause   <= 2'b00;
         o_overrun <= 1'b0;
      end else begin
         if (push_ok)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         if (state == RUN) begin
            if (i_status_valid) begin
               seq  <= seq + 8'd1;
               tcnt <= '0;
               if (!push_ok)
                  o_overrun <= 1'b1;
               case (i_status)
                  2'b00: if (o_r_cnt != CMAX) o_r_cnt <= o_r_cnt + 1'b1;
                  2'b01: if (o_i_cnt != CMAX) o_i_cnt <= o_i_cnt + 1'b1;
                  2'b10: begin
                     state   <= DONE;
                     o_done  <= 1'b1;
                     o_cause <= 2'b10;
                  end
                  default: begin
                     state   <= DONE;
                     o_done  <= 1'b1;
                     o_cause <= 2'b01;
                  end
               endcase
            end else if (tcnt == TLAST) begin
               state   <= DONE;
               o_done  <= 1'b1;
               o_cause <= 2'b11;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_core_status_monitor.sv
// Directed bench for core_status_monitor: logging, counters, halt causes, overrun, timeout,
// sequence wrap, counter saturation (second instance with 4-bit counters) and reset/re-arm.
module tb_core_status_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  status;
   logic        status_valid;
   logic        rec_ready;

   logic        rec_valid;
   logic [9:0]  rec_data;
   logic [15:0] r_cnt;
   logic [15:0] i_cnt;
   logic        done;
   logic [1:0]  cause;
   logic        overrun;

   logic        sat_rec_valid;
   logic [9:0]  sat_rec_data;
   logic [3:0]  sat_r_cnt;
   logic [3:0]  sat_i_cnt;
   logic        sat_done;
   logic [1:0]  sat_cause;
   logic        sat_overrun;

   int checks = 0;
   int errors = 0;
   int pops;

   always #5 clk = ~clk;

   core_status_monitor #(.DEPTH(16), .TIMEOUT(64), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_status(status),
      .i_status_valid(status_valid), .o_rec_valid(rec_valid), .o_rec_data(rec_data),
      .i_rec_ready(rec_ready), .o_r_cnt(r_cnt), .o_i_cnt(i_cnt), .o_done(done),
      .o_cause(cause), .o_overrun(overrun)
   );

   core_status_monitor #(.DEPTH(16), .TIMEOUT(64), .CNT_W(4)) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_status(status),
      .i_status_valid(status_valid), .o_rec_valid(sat_rec_valid), .o_rec_data(sat_rec_data),
      .i_rec_ready(rec_ready), .o_r_cnt(sat_r_cnt), .o_i_cnt(sat_i_cnt), .o_done(sat_done),
      .o_cause(sat_cause), .o_overrun(sat_overrun)
   );

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] s);
      status_valid = v;
      status       = s;
      tick();
      status_valid = 1'b0;
   endtask

   task automatic armMonitor();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; status = 2'b00; status_valid = 1'b0; rec_ready = 1'b0;
      tick();
      tick();
      checkOutput("rst_rec_valid", rec_valid, 0);
      checkOutput("rst_rec_data", rec_data, 0);
      checkOutput("rst_r_cnt", r_cnt, 0);
      checkOutput("rst_i_cnt", i_cnt, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_cause", cause, 0);
      checkOutput("rst_overrun", overrun, 0);
      rst = 1'b0;

      // Test 1: basic stream ending with 11
      $display("[TB] test 1: basic stream");
      armMonitor();
      rec_ready = 1'b1;
      applyStimulus(1'b1, 2'b00);
      checkOutput("t1_valid0", rec_valid, 1);
      checkOutput("t1_rec0", rec_data, 10'h000);
      applyStimulus(1'b1, 2'b01);
      checkOutput("t1_rec1", rec_data, 10'h005);
      applyStimulus(1'b1, 2'b00);
      checkOutput("t1_rec2", rec_data, 10'h008);
      checkOutput("t1_done_early", done, 0);
      applyStimulus(1'b1, 2'b11);
      checkOutput("t1_rec3", rec_data, 10'h00F);
      checkOutput("t1_done", done, 1);
      checkOutput("t1_cause", cause, 1);
      checkOutput("t1_r_cnt", r_cnt, 2);
      checkOutput("t1_i_cnt", i_cnt, 1);
      tick();
      checkOutput("t1_drained", rec_valid, 0);

      // Test 2: overflow halt, trailing status ignored; re-arm from DONE clears
      $display("[TB] test 2: overflow");
      armMonitor();
      checkOutput("t2_rearm_done", done, 0);
      checkOutput("t2_rearm_cause", cause, 0);
      checkOutput("t2_rearm_r_cnt", r_cnt, 0);
      applyStimulus(1'b1, 2'b01);
      checkOutput("t2_rec0", rec_data, 10'h001);
      applyStimulus(1'b1, 2'b10);
      checkOutput("t2_rec1", rec_data, 10'h006);
      checkOutput("t2_cause", cause, 2);
      applyStimulus(1'b1, 2'b00);
      checkOutput("t2_empty", rec_valid, 0);
      checkOutput("t2_r_cnt", r_cnt, 0);
      checkOutput("t2_i_cnt", i_cnt, 1);
      checkOutput("t2_cause_hold", cause, 2);

      // Test 3: overrun with reader stalled, then full push+pop, then drain
      $display("[TB] test 3: overrun");
      armMonitor();
      rec_ready = 1'b0;
      for (int k = 0; k < 20; k++)
         applyStimulus(1'b1, 2'b00);
      checkOutput("t3_overrun", overrun, 1);
      checkOutput("t3_r_cnt", r_cnt, 20);
      checkOutput("t3_sat_r_cnt", sat_r_cnt, 15);
      checkOutput("t3_head", rec_data, 10'h000);
      rec_ready = 1'b1;
      applyStimulus(1'b1, 2'b00);
      checkOutput("t3_pushpop_head", rec_data, 10'h004);
      checkOutput("t3_overrun_sticky", overrun, 1);
      checkOutput("t3_r_cnt_21", r_cnt, 21);
      checkOutput("t3_sat_hold", sat_r_cnt, 15);
      pops = 0;
      for (int k = 0; k < 40 && rec_valid; k++) begin
         checkOutput($sformatf("t3_drain%0d", k), rec_data,
                     {(k < 15) ? 8'(k + 1) : 8'd20, 2'b00});
         tick();
         pops++;
      end
      checkOutput("t3_pop_count", pops, 16);
      checkOutput("t3_empty", rec_valid, 0);

      // Test 4: start in RUN is ignored; timeout fires exactly TIMEOUT cycles after last status
      $display("[TB] test 4: timeout");
      armMonitor();
      checkOutput("t4_start_ignored", r_cnt, 21);
      applyStimulus(1'b1, 2'b11);
      checkOutput("t4_end_cause", cause, 1);
      armMonitor();
      checkOutput("t4_overrun_clr", overrun, 0);
      applyStimulus(1'b1, 2'b00);
      repeat (63) tick();
      checkOutput("t4_no_done_63", done, 0);
      tick();
      checkOutput("t4_done_64", done, 1);
      checkOutput("t4_cause_to", cause, 3);
      armMonitor();
      applyStimulus(1'b1, 2'b00);
      repeat (62) tick();
      applyStimulus(1'b1, 2'b01);
      checkOutput("t4_saved_63", done, 0);
      tick();
      checkOutput("t4_saved_64", done, 0);
      applyStimulus(1'b1, 2'b11);

      // Test 5: sequence wrap with continuous drain
      $display("[TB] test 5: seq wrap");
      armMonitor();
      for (int k = 0; k < 300; k++) begin
         applyStimulus(1'b1, 2'b00);
         if (k == 255) checkOutput("t5_seq255", rec_data, 10'h3FC);
         if (k == 256) checkOutput("t5_seq0", rec_data, 10'h000);
      end
      checkOutput("t5_r_cnt", r_cnt, 300);
      checkOutput("t5_sat_r_cnt", sat_r_cnt, 15);
      checkOutput("t5_overrun", overrun, 0);

      // Test 6: reset mid-RUN, IDLE ignores statuses, start-cycle status ignored, re-arm flushes
      $display("[TB] test 6: reset and re-arm");
      tick();
      rec_ready = 1'b0;
      for (int k = 0; k < 5; k++)
         applyStimulus(1'b1, 2'b01);
      checkOutput("t6_pending", rec_valid, 1);
      checkOutput("t6_i_cnt", i_cnt, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t6_rst_valid", rec_valid, 0);
      checkOutput("t6_rst_data", rec_data, 0);
      checkOutput("t6_rst_r_cnt", r_cnt, 0);
      checkOutput("t6_rst_i_cnt", i_cnt, 0);
      checkOutput("t6_rst_done", done, 0);
      checkOutput("t6_rst_cause", cause, 0);
      checkOutput("t6_rst_overrun", overrun, 0);
      for (int k = 0; k < 3; k++)
         applyStimulus(1'b1, 2'b00);
      checkOutput("t6_idle_r_cnt", r_cnt, 0);
      checkOutput("t6_idle_valid", rec_valid, 0);
      status_valid = 1'b1;
      status       = 2'b00;
      armMonitor();
      checkOutput("t6_startcyc_r_cnt", r_cnt, 0);
      checkOutput("t6_startcyc_valid", rec_valid, 0);
      applyStimulus(1'b1, 2'b01);
      applyStimulus(1'b1, 2'b11);
      applyStimulus(1'b1, 2'b00);
      checkOutput("t6_done_ignore", r_cnt, 0);
      checkOutput("t6_done_cause", cause, 1);
      checkOutput("t6_done_pending", rec_valid, 1);
      armMonitor();
      checkOutput("t6_rearm_flush", rec_valid, 0);
      checkOutput("t6_rearm_i_cnt", i_cnt, 0);
      checkOutput("t6_rearm_cause", cause, 0);
      checkOutput("t6_rearm_done", done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_status_monitor.md
# core_status_monitor

- Receiving end of the core's per-instruction status stream (`o_status` / `o_status_valid`).
- Records each reported status into a buffered log, keeps per-class instruction counters and detects program termination (end, overflow, or watchdog timeout).
- Drains the log to a host/bench reader over a valid/ready handshake.
- Sits beside the core, alongside the instruction and data memories.

## Interface
Parameters:
- DEPTH, 16: log FIFO entries; power of 2, ≥ 2.
- TIMEOUT, 64: cycles in RUN without a status before a timeout halt; ≥ 2.
- CNT_W, 16: width of each class counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  arms the monitor (single-cycle pulse).
- i_status  in  2  core status code: 00 R-type ok, 01 I-type ok, 10 overflow, 11 end.
- i_status_valid  in  1  i_status is valid this cycle.
- o_rec_valid  out  1  log head is available.
- o_rec_data  out  10  log head: {seq[7:0], status[1:0]}.
- i_rec_ready  in  1  reader accepts the head this cycle.
- o_r_cnt  out  CNT_W  R-type successes.
- o_i_cnt  out  CNT_W  I-type successes.
- o_done  out  1  monitor in DONE.
- o_cause  out  2  halt cause: 00 none, 01 end, 10 overflow, 11 timeout.
- o_overrun  out  1  sticky; a status was dropped because the log was full.

## Operation
FSM states: IDLE, RUN, DONE.

**IDLE**
- i_status_valid is ignored.
- i_start → RUN. On the same edge, clear counters, seq, o_cause, o_overrun, the timeout counter and the FIFO.

**RUN**
- Each sampled valid status:
  - pushes {seq, status} into the FIFO;
  - increments seq (8-bit, wraps 255→0);
  - increments the matching counter: 00 → o_r_cnt, 01 → o_i_cnt;
  - clears the timeout counter.
- Counters saturate at all-ones and never wrap.
- Status 11 → DONE with cause 01. Status 10 → DONE with cause 10. The terminal record is still pushed.
- Timeout counter:
  - increments on each RUN cycle without a valid;
  - on reaching TIMEOUT-1 with no valid that cycle → DONE, cause 11, nothing pushed.
- i_start in RUN is ignored.

**DONE**
- Statuses are ignored.
- FIFO keeps draining.
- Counters and cause hold.
- i_start → RUN with the same clearing as from IDLE, including flushing any undrained records.

**FIFO**
- Standard circular buffer; pointers are log2(DEPTH)+1 bits.
- A push when full and not popping this cycle is dropped: sets o_overrun. Seq still increments and counters still update.
- Push and pop in the same cycle when full: both succeed, occupancy unchanged.
- Push and pop in the same cycle when empty: the push lands; nothing pops (o_rec_valid was 0).
- Pop occurs when o_rec_valid && i_rec_ready.

**Reset**
- i_rst has priority over every other input.
- Returns to IDLE and clears the FIFO.
- All outputs 0: o_rec_valid, o_rec_data, o_r_cnt, o_i_cnt, o_done, o_cause, o_overrun.
- Reset during RUN with records pending discards them.

## Timing
- Status sampled at edge n:
  - counters, seq and FIFO update at edge n;
  - o_rec_valid (if the FIFO was empty) and new counter values are visible from cycle n+1.
- o_rec_data is driven from FIFO storage and follows the head pointer combinationally. It is stable while o_rec_valid && !i_rec_ready.
- o_rec_valid is a function of registered state only; it never depends on i_rec_ready.
- Terminal status at edge n: o_done=1 and o_cause valid from cycle n+1.
- Timeout:
  - last valid at edge n → o_done rises at cycle n+TIMEOUT;
  - with TIMEOUT=64, a status at edge n+63 prevents the timeout.
- i_start at edge n → state RUN from cycle n+1; a status in that same cycle n is ignored.
- One push per cycle maximum. Throughput: one record per cycle in each direction.

## Test plan
1. **Reset.** Reset, then i_start, then statuses 00,01,00,11 on consecutive cycles, i_rec_ready=1 → records {0,00},{1,01},{2,00},{3,11} in order; o_r_cnt=2, o_i_cnt=1, o_cause=01, o_done one cycle after the 11.
2. **Overflow and ignore-after-halt.** Statuses 01,10, then 00 → o_cause=10; the trailing 00 is ignored (o_r_cnt=0); two records logged.
3. **Overrun.** DEPTH=16, i_rec_ready=0, 20 statuses of 00 → o_overrun=1, 16 records seq 0..15, o_r_cnt=20. Then assert i_rec_ready → exactly 16 pops. Full + simultaneous push/pop keeps the count at 16.
4. **Timeout.** TIMEOUT=64: one status, then idle → o_done and o_cause=11 exactly 64 cycles after the status edge. A status at cycle 63 instead → no timeout.
5. **Seq wrap.** 300 statuses with continuous drain → seq 255 followed by 0. Saturation: CNT_W=4 with 20 R-type statuses → o_r_cnt=15.
6. **Reset and re-arm.** i_rst mid-RUN with 5 pending records → all outputs 0 next cycle, o_rec_valid=0. Statuses in IDLE ignored. Re-arm from DONE via i_start → counters and cause cleared.
